// File: rtl/axi4_lite_pkg.sv
// Shared state and response encodings for the AXI4-Lite BRAM responder.
// Pure type/constant package; no logic, no latency, no flow control.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    e_ready      = 2'd0,
    e_read_resp  = 2'd1,
    e_write_resp = 2'd2
  } axi4_lite_resp_state_e;

  typedef enum logic [1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } axi4_lite_resp_e;

  // Number of low address bits that select a byte within one data word.
  function automatic int unsigned byte_offset_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables; read data is registered (1 cycle) and
// holds its value until the next read access. No backpressure: one access per cycle when v_i is high.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int width_p = 64,
  parameter int els_p   = 4096
) (
  input  logic                       clk_i,
  input  logic                       v_i,
  input  logic                       w_i,
  input  logic [$clog2(els_p)-1:0]   addr_i,
  input  logic [width_p-1:0]         data_i,
  input  logic [width_p/8-1:0]       write_mask_i,
  output logic [width_p-1:0]         data_o
);

  localparam int bytes_lp = width_p / 8;

  logic [width_p-1:0] mem_r [els_p];

  // Contents are intentionally left unreset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (write_mask_i[b]) begin
          mem_r[addr_i][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
    if (v_i & ~w_i) begin
      data_o <= mem_r[addr_i];
    end
  end

endmodule

// File: rtl/axi4_lite_bram_responder.sv
// AXI4-Lite responder on block RAM: single-beat R/W, response valid 1 cycle after handshake, held until ready.
// Readies are combinational and only high in e_ready; AXI4_LITE_BRAM_DECERR_EN adds a DECERR range check.
module axi4_lite_bram_responder
  import axi4_lite_pkg::*;
#(
  parameter int                          axi_addr_width_p = 28,
  parameter int                          axi_data_width_p = 64,
  parameter int                          els_p            = 4096,
  parameter logic [axi_addr_width_p-1:0] base_addr_p      = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic [axi_addr_width_p-1:0]   awaddr_i,
  input  logic [2:0]                    awprot_i,
  input  logic                          awvalid_i,
  output logic                          awready_o,

  input  logic [axi_data_width_p-1:0]   wdata_i,
  input  logic [axi_data_width_p/8-1:0] wstrb_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,

  output logic [1:0]                    bresp_o,
  output logic                          bvalid_o,
  input  logic                          bready_i,

  input  logic [axi_addr_width_p-1:0]   araddr_i,
  input  logic [2:0]                    arprot_i,
  input  logic                          arvalid_i,
  output logic                          arready_o,

  output logic [axi_data_width_p-1:0]   rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rvalid_o,
  input  logic                          rready_i
);

  localparam int byte_lg_lp = byte_offset_bits(axi_data_width_p);
  localparam int lg_els_lp  = $clog2(els_p);

  axi4_lite_resp_state_e state_r, state_n;
  axi4_lite_resp_e       resp_r;
  logic                  last_grant_write_r;

  logic [axi_addr_width_p-1:0] aw_offset, ar_offset;
  logic [lg_els_lp-1:0]        aw_idx, ar_idx;
  logic                        aw_in_range, ar_in_range;

  logic write_cand, read_cand, grant_write, grant_read;
  logic in_ready, write_hs, read_hs;

  logic                          mem_v, mem_w;
  logic [lg_els_lp-1:0]          mem_addr;
  logic [axi_data_width_p-1:0]   mem_rdata;

  // Subtracting the base before dropping byte bits lets an unaligned base still index word 0 correctly.
  assign aw_offset = awaddr_i - base_addr_p;
  assign ar_offset = araddr_i - base_addr_p;
  assign aw_idx    = aw_offset[byte_lg_lp +: lg_els_lp];
  assign ar_idx    = ar_offset[byte_lg_lp +: lg_els_lp];

`ifdef AXI4_LITE_BRAM_DECERR_EN
  localparam logic [64:0] range_bytes_lp = 65'(els_p) * 65'(axi_data_width_p / 8);

  assign aw_in_range = (awaddr_i >= base_addr_p) && (65'(aw_offset) < range_bytes_lp);
  assign ar_in_range = (araddr_i >= base_addr_p) && (65'(ar_offset) < range_bytes_lp);
`else
  assign aw_in_range = 1'b1;
  assign ar_in_range = 1'b1;
`endif

  logic unused_ok;
  assign unused_ok = ^{awprot_i, arprot_i, aw_offset, ar_offset};

  // AW and W are only ever taken together; on contention the grant alternates.
  assign write_cand  = awvalid_i & wvalid_i;
  assign read_cand   = arvalid_i;
  assign grant_write = write_cand & (~read_cand | ~last_grant_write_r);
  assign grant_read  = read_cand & (~write_cand | last_grant_write_r);

  assign in_ready = (state_r == e_ready) & reset_n_i;
  assign write_hs = in_ready & grant_write;
  assign read_hs  = in_ready & grant_read;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r            <= e_ready;
      last_grant_write_r <= 1'b0;
      resp_r             <= e_axi_resp_okay;
    end else begin
      state_r <= state_n;
      if (write_hs) begin
        last_grant_write_r <= 1'b1;
        resp_r             <= aw_in_range ? e_axi_resp_okay : e_axi_resp_decerr;
      end else if (read_hs) begin
        last_grant_write_r <= 1'b0;
        resp_r             <= ar_in_range ? e_axi_resp_okay : e_axi_resp_decerr;
      end
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready: begin
        if (write_hs) begin
          state_n = e_write_resp;
        end else if (read_hs) begin
          state_n = e_read_resp;
        end
      end
      e_read_resp:  if (rready_i) state_n = e_ready;
      e_write_resp: if (bready_i) state_n = e_ready;
      default:      state_n = e_ready;
    endcase
  end

  // RAM read data stays put while the response waits, since the port is idle outside e_ready.
  always_comb begin
    awready_o = in_ready & grant_write;
    wready_o  = in_ready & grant_write;
    arready_o = in_ready & grant_read;
    bvalid_o  = (state_r == e_write_resp);
    rvalid_o  = (state_r == e_read_resp);
    bresp_o   = bvalid_o ? resp_r : e_axi_resp_okay;
    rresp_o   = rvalid_o ? resp_r : e_axi_resp_okay;
    rdata_o   = (rvalid_o && resp_r == e_axi_resp_okay) ? mem_rdata : '0;
    mem_w     = write_hs;
    mem_v     = (write_hs & aw_in_range) | (read_hs & ar_in_range);
    mem_addr  = grant_write ? aw_idx : ar_idx;
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .width_p (axi_data_width_p),
    .els_p   (els_p)
  ) mem (
    .clk_i        (clk_i),
    .v_i          (mem_v),
    .w_i          (mem_w),
    .addr_i       (mem_addr),
    .data_i       (wdata_i),
    .write_mask_i (wstrb_i),
    .data_o       (mem_rdata)
  );

endmodule

// File: tb/tb_axi4_lite_bram_responder.sv
// Directed bench for axi4_lite_bram_responder: reset, R/W data path, strobes, backpressure,
// arbitration and the optional AXI4_LITE_BRAM_DECERR_EN range check.
module tb_axi4_lite_bram_responder;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [27:0] awaddr_i, araddr_i;
  logic [2:0]  awprot_i, arprot_i;
  logic        awvalid_i, wvalid_i, arvalid_i, bready_i, rready_i;
  logic        awready_o, wready_o, arready_o, bvalid_o, rvalid_o;
  logic [63:0] wdata_i, rdata_o;
  logic [7:0]  wstrb_i;
  logic [1:0]  bresp_o, rresp_o;

  int vectors     = 0;
  int miscompares = 0;

  axi4_lite_bram_responder dut (
    .clk_i     (clk_i),     .reset_n_i (reset_n_i),
    .awaddr_i  (awaddr_i),  .awprot_i  (awprot_i),  .awvalid_i (awvalid_i), .awready_o (awready_o),
    .wdata_i   (wdata_i),   .wstrb_i   (wstrb_i),   .wvalid_i  (wvalid_i),  .wready_o  (wready_o),
    .bresp_o   (bresp_o),   .bvalid_o  (bvalid_o),  .bready_i  (bready_i),
    .araddr_i  (araddr_i),  .arprot_i  (arprot_i),  .arvalid_i (arvalid_i), .arready_o (arready_o),
    .rdata_o   (rdata_o),   .rresp_o   (rresp_o),   .rvalid_o  (rvalid_o),  .rready_i  (rready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    awvalid_i = 0; wvalid_i = 0; arvalid_i = 0; bready_i = 0; rready_i = 0;
    awprot_i = 0; arprot_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    reset_n_i = 0;
    repeat (4) @(negedge clk_i);
    reset_n_i = 1;
  endtask

  // Handshake one write; reports whether it was accepted and the response seen one cycle later.
  task automatic axi_write(input logic [27:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           output bit done, output logic bv, output logic [1:0] resp);
    @(negedge clk_i);
    awaddr_i = addr; wdata_i = data; wstrb_i = strb; awvalid_i = 1; wvalid_i = 1;
    #1;
    for (int n = 0; n < 16 && !(awready_o && wready_o); n++) begin
      @(negedge clk_i); #1;
    end
    done = awready_o && wready_o;
    @(posedge clk_i); #1;
    awvalid_i = 0; wvalid_i = 0;
    bv = bvalid_o; resp = bresp_o;
    bready_i = 1;
    @(posedge clk_i); #1;
    bready_i = 0;
  endtask

  task automatic axi_read(input logic [27:0] addr, output bit done, output logic rv,
                          output logic [63:0] data, output logic [1:0] resp);
    @(negedge clk_i);
    araddr_i = addr; arvalid_i = 1;
    #1;
    for (int n = 0; n < 16 && !arready_o; n++) begin
      @(negedge clk_i); #1;
    end
    done = arready_o;
    @(posedge clk_i); #1;
    arvalid_i = 0;
    rv = rvalid_o; data = rdata_o; resp = rresp_o;
    rready_i = 1;
    @(posedge clk_i); #1;
    rready_i = 0;
  endtask

  task automatic test_reset();
    bit d; logic v; logic [1:0] r; logic [63:0] q;
    idle_inputs();
    reset_n_i = 0;
    awvalid_i = 1; wvalid_i = 1; arvalid_i = 1;
    awaddr_i = 28'h80; araddr_i = 28'h80; wdata_i = 64'hBAD0_BAD0_BAD0_BAD0; wstrb_i = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      vectors++;
      if ({awready_o, wready_o, arready_o, bvalid_o, rvalid_o} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_hs[%0d]: got %b expected 00000", c,
                 {awready_o, wready_o, arready_o, bvalid_o, rvalid_o});
      end
    end
    vectors++;
    if ({rdata_o, rresp_o, bresp_o} !== 68'h0) begin
      miscompares++;
      $display("FAIL reset_data: got rdata %h rresp %b bresp %b expected all zero", rdata_o, rresp_o, bresp_o);
    end
    idle_inputs();
    reset_n_i = 1;

    axi_write(28'h80, 64'hA5A5_0000_1234_5678, 8'hFF, d, v, r);
    // Leave a read response pending, then reset over it with writes requested.
    @(negedge clk_i);
    araddr_i = 28'h80; arvalid_i = 1;
    @(posedge clk_i); #1;
    arvalid_i = 0;
    vectors++;
    if (rvalid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_read: got rvalid %b expected 1", rvalid_o);
    end
    @(negedge clk_i);
    reset_n_i = 0;
    awvalid_i = 1; wvalid_i = 1; awaddr_i = 28'h80; wdata_i = 64'hBAD0_BAD0_BAD0_BAD0; wstrb_i = 8'hFF;
    @(posedge clk_i); #1;
    vectors++;
    if ({rvalid_o, awready_o, wready_o} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_drop: got rvalid/awready/wready %b expected 000", {rvalid_o, awready_o, wready_o});
    end
    repeat (3) @(negedge clk_i);
    idle_inputs();
    reset_n_i = 1;
    axi_read(28'h80, d, v, q, r);
    vectors++;
    if (!d || v !== 1'b1 || q !== 64'hA5A5_0000_1234_5678 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_no_write: got done %0d rvalid %b rdata %h rresp %b expected 1 1 a5a5000012345678 00",
               d, v, q, r);
    end
  endtask

  task automatic test_write_read();
    bit d; logic v; logic [1:0] r; logic [63:0] q;
    axi_write(28'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF, d, v, r);
    vectors++;
    if (!d || v !== 1'b1 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL write_resp: got done %0d bvalid %b bresp %b expected 1 1 00", d, v, r);
    end
    axi_read(28'h40, d, v, q, r);
    vectors++;
    if (!d || v !== 1'b1 || q !== 64'hDEADBEEF_CAFEF00D || r !== 2'b00) begin
      miscompares++;
      $display("FAIL read_back: got done %0d rvalid %b rdata %h rresp %b expected 1 1 deadbeefcafef00d 00",
               d, v, q, r);
    end
    axi_read(28'h47, d, v, q, r);
    vectors++;
    if (q !== 64'hDEADBEEF_CAFEF00D) begin
      miscompares++;
      $display("FAIL byte_offset_ignored: got %h expected deadbeefcafef00d", q);
    end
  endtask

  task automatic test_partial_strobe();
    bit d; logic v; logic [1:0] r; logic [63:0] q;
    axi_write(28'h40, 64'h11223344_55667788, 8'h0F, d, v, r);
    axi_read(28'h40, d, v, q, r);
    vectors++;
    if (q !== 64'hDEADBEEF_55667788) begin
      miscompares++;
      $display("FAIL strobe_0f: got %h expected deadbeef55667788", q);
    end
    axi_write(28'h40, 64'hFFFFFFFF_FFFFFFFF, 8'h00, d, v, r);
    vectors++;
    if (!d || v !== 1'b1 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL strobe_00_resp: got done %0d bvalid %b bresp %b expected 1 1 00", d, v, r);
    end
    axi_read(28'h40, d, v, q, r);
    vectors++;
    if (q !== 64'hDEADBEEF_55667788) begin
      miscompares++;
      $display("FAIL strobe_00_data: got %h expected deadbeef55667788", q);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk_i);
    araddr_i = 28'h40; arvalid_i = 1;
    @(posedge clk_i); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      vectors++;
      if (rvalid_o !== 1'b1 || rdata_o !== 64'hDEADBEEF_55667788 || rresp_o !== 2'b00 || arready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: got rvalid %b rdata %h rresp %b arready %b expected 1 deadbeef55667788 00 0",
                 c, rvalid_o, rdata_o, rresp_o, arready_o);
      end
    end
    arvalid_i = 0; rready_i = 1;
    @(posedge clk_i); #1;
    rready_i = 0;
    vectors++;
    if (rvalid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release: got rvalid %b expected 0", rvalid_o);
    end
  endtask

  task automatic test_contention();
    bit   is_write [8];
    int   cyc [8];
    int   idx = 0;
    bit   overlap = 0;
    do_reset();
    @(negedge clk_i);
    awaddr_i = 28'h100; araddr_i = 28'h100; wdata_i = 64'h0F0F_1234_ABCD_5555; wstrb_i = 8'hFF;
    awvalid_i = 1; wvalid_i = 1; arvalid_i = 1; bready_i = 1; rready_i = 1;
    #1;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      if (awready_o && arready_o) overlap = 1;
      if (rvalid_o) begin
        vectors++;
        if (rdata_o !== 64'h0F0F_1234_ABCD_5555) begin
          miscompares++;
          $display("FAIL contention_rdata: got %h expected 0f0f1234abcd5555", rdata_o);
        end
      end
      if (awready_o) begin
        is_write[idx] = 1; cyc[idx] = c; idx++;
      end else if (arready_o) begin
        is_write[idx] = 0; cyc[idx] = c; idx++;
      end
      @(negedge clk_i); #1;
    end
    awvalid_i = 0; wvalid_i = 0; arvalid_i = 0;
    repeat (2) @(negedge clk_i);
    bready_i = 0; rready_i = 0;
    vectors++;
    if (idx != 8 || overlap) begin
      miscompares++;
      $display("FAIL contention_count: got %0d grants overlap %0d expected 8 grants overlap 0", idx, overlap);
    end
    for (int i = 0; i < idx; i++) begin
      vectors++;
      if (is_write[i] !== ((i % 2) == 0) || cyc[i] != 2 * i) begin
        miscompares++;
        $display("FAIL contention_grant[%0d]: got write %0d at cycle %0d expected write %0d at cycle %0d",
                 i, is_write[i], cyc[i], (i % 2) == 0, 2 * i);
      end
    end
  endtask

  task automatic test_out_of_range();
    bit d; logic v; logic [1:0] r; logic [63:0] q;
    axi_write(28'h0, 64'h01234567_89ABCDEF, 8'hFF, d, v, r);
`ifdef AXI4_LITE_BRAM_DECERR_EN
    axi_read(28'h8000, d, v, q, r);
    vectors++;
    if (!d || v !== 1'b1 || r !== 2'b11 || q !== 64'h0) begin
      miscompares++;
      $display("FAIL oor_read: got done %0d rvalid %b rresp %b rdata %h expected 1 1 11 0", d, v, r, q);
    end
    axi_write(28'h8000, 64'hFEEDFACE_FEEDFACE, 8'hFF, d, v, r);
    vectors++;
    if (!d || v !== 1'b1 || r !== 2'b11) begin
      miscompares++;
      $display("FAIL oor_write_resp: got done %0d bvalid %b bresp %b expected 1 1 11", d, v, r);
    end
    axi_read(28'h0, d, v, q, r);
    vectors++;
    if (q !== 64'h01234567_89ABCDEF || r !== 2'b00) begin
      miscompares++;
      $display("FAIL oor_word0_kept: got %h resp %b expected 0123456789abcdef 00", q, r);
    end
`else
    axi_write(28'h8000, 64'hFEEDFACE_FEEDFACE, 8'hFF, d, v, r);
    vectors++;
    if (!d || v !== 1'b1 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL wrap_write_resp: got done %0d bvalid %b bresp %b expected 1 1 00", d, v, r);
    end
    axi_read(28'h0, d, v, q, r);
    vectors++;
    if (q !== 64'hFEEDFACE_FEEDFACE || r !== 2'b00) begin
      miscompares++;
      $display("FAIL wrap_word0: got %h resp %b expected feedfacefeedface 00", q, r);
    end
    axi_read(28'h8000, d, v, q, r);
    vectors++;
    if (q !== 64'hFEEDFACE_FEEDFACE || r !== 2'b00) begin
      miscompares++;
      $display("FAIL wrap_read: got %h resp %b expected feedfacefeedface 00", q, r);
    end
`endif
  endtask

  initial begin
    awaddr_i = 0; araddr_i = 0; wdata_i = 0; wstrb_i = 0;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_backpressure();
    test_contention();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
